// File: rtl/sw_debounce.sv
// Per-bit switch conditioner: two-flop synchroniser followed by a tick-gated
// debounce counter, producing clean levels plus registered rise/fall/changed pulses.
module sw_debounce #(
  parameter int N      = 16,
  parameter int STABLE = 4
) (
  input  logic         CLK100MHZ,
  input  logic         rst,
  input  logic         tick,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] sw_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         changed
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  logic [N-1:0] sync1_reg;
  logic [N-1:0] sync2_reg;
  logic [N-1:0] sw_out_reg;
  logic [N-1:0] sw_out_next;
  logic [N-1:0] rise_reg;
  logic [N-1:0] rise_next;
  logic [N-1:0] fall_reg;
  logic [N-1:0] fall_next;
  logic         changed_reg;
  logic         changed_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          mismatch;
      logic          accept;

      assign mismatch = sync2_reg[gi] ^ sw_out_reg[gi];
      assign accept   = tick && mismatch && (cnt_reg == LAST);

      // Any matching tick drops back to idle, so short glitches never accumulate.
      always_comb begin
        cnt_next = cnt_reg;
        if (tick) begin
          if (!mismatch || accept) begin
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end

      always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign sw_out_next[gi] = accept ? sync2_reg[gi] : sw_out_reg[gi];
      assign rise_next[gi]   = accept &  sync2_reg[gi];
      assign fall_next[gi]   = accept & ~sync2_reg[gi];
    end
  endgenerate

  assign changed_next = |(rise_next | fall_next);

  // Pulses are registered alongside sw_out so they coincide with the new level.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      sw_out_reg  <= '0;
      rise_reg    <= '0;
      fall_reg    <= '0;
      changed_reg <= 1'b0;
    end else begin
      sync1_reg   <= sw_in;
      sync2_reg   <= sync1_reg;
      sw_out_reg  <= sw_out_next;
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
      changed_reg <= changed_next;
    end
  end

  assign sw_out  = sw_out_reg;
  assign rise    = rise_reg;
  assign fall    = fall_reg;
  assign changed = changed_reg;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (N=16, STABLE=4): reset, glitch rejection,
// bounce acceptance, simultaneous change, tick gating and mid-debounce reset.
module tb_sw_debounce;

  logic        CLK100MHZ = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [15:0] sw_in = 16'h0000;
  logic [15:0] sw_out;
  logic [15:0] rise;
  logic [15:0] fall;
  logic        changed;

  int checks = 0;
  int errors = 0;

  sw_debounce #(.N(16), .STABLE(4)) dut (
    .CLK100MHZ(CLK100MHZ),
    .rst(rst),
    .tick(tick),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .rise(rise),
    .fall(fall),
    .changed(changed)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge; outputs are observed 1 time unit after it.
  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; sw_in = 16'hFFFF;
    step(); step();
    checks++; if (sw_out !== 16'h0000) begin errors++; $display("FAIL reset_sw_out: got %h expected %h", sw_out, 16'h0000); end
    checks++; if (rise !== 16'h0000) begin errors++; $display("FAIL reset_rise: got %h expected %h", rise, 16'h0000); end
    checks++; if (fall !== 16'h0000) begin errors++; $display("FAIL reset_fall: got %h expected %h", fall, 16'h0000); end
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b expected %b", changed, 1'b0); end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (sw_out !== 16'h0000 || changed !== 1'b0) begin errors++; $display("FAIL release_wait clk%0d: sw_out %h changed %b expected 0000 0", k, sw_out, changed); end
    end
    step();
    checks++; if (sw_out !== 16'hFFFF) begin errors++; $display("FAIL release_sw_out: got %h expected %h", sw_out, 16'hFFFF); end
    checks++; if (rise !== 16'hFFFF) begin errors++; $display("FAIL release_rise: got %h expected %h", rise, 16'hFFFF); end
    checks++; if (fall !== 16'h0000) begin errors++; $display("FAIL release_fall: got %h expected %h", fall, 16'h0000); end
    checks++; if (changed !== 1'b1) begin errors++; $display("FAIL release_changed: got %b expected %b", changed, 1'b1); end
    step();
    checks++; if (rise !== 16'h0000 || changed !== 1'b0) begin errors++; $display("FAIL release_pulse_width: rise %h changed %b expected 0000 0", rise, changed); end
    checks++; if (sw_out !== 16'hFFFF) begin errors++; $display("FAIL release_hold: got %h expected %h", sw_out, 16'hFFFF); end
    $display("test_reset done");
  endtask

  task automatic test_glitch();
    rst = 1'b1; tick = 1'b0; sw_in = 16'h0000;
    step();
    rst = 1'b0;
    sw_in = 16'h0008;
    // Ticks at i=9,19,29 see the high level; input returns low before i=39.
    for (int i = 0; i < 80; i++) begin
      if (i == 30) sw_in = 16'h0000;
      tick = (i % 10 == 9);
      step();
      checks++; if (sw_out !== 16'h0000 || changed !== 1'b0 || rise !== 16'h0000 || fall !== 16'h0000) begin
        errors++; $display("FAIL glitch i%0d: sw_out %h rise %h fall %h changed %b expected 0000 0000 0000 0", i, sw_out, rise, fall, changed);
      end
    end
    tick = 1'b0;
    // Count was cleared: a fresh high level needs a full four ticks.
    sw_in = 16'h0008;
    idle(2);
    for (int k = 1; k <= 3; k++) begin
      do_tick(); idle(9);
      checks++; if (sw_out !== 16'h0000) begin errors++; $display("FAIL glitch_rearm tick%0d: got %h expected %h", k, sw_out, 16'h0000); end
    end
    do_tick();
    checks++; if (sw_out !== 16'h0008) begin errors++; $display("FAIL glitch_accept_sw_out: got %h expected %h", sw_out, 16'h0008); end
    checks++; if (rise !== 16'h0008) begin errors++; $display("FAIL glitch_accept_rise: got %h expected %h", rise, 16'h0008); end
    idle(9);
    $display("test_glitch done");
  endtask

  task automatic test_bounce();
    sw_in = 16'h0009; idle(2);
    do_tick(); idle(9);
    checks++; if (sw_out !== 16'h0008 || fall !== 16'h0000) begin errors++; $display("FAIL bounce_1: sw_out %h fall %h expected 0008 0000", sw_out, fall); end
    sw_in = 16'h0008; idle(9);
    do_tick();
    checks++; if (sw_out !== 16'h0008 || fall !== 16'h0000) begin errors++; $display("FAIL bounce_0: sw_out %h fall %h expected 0008 0000", sw_out, fall); end
    idle(9);
    sw_in = 16'h0009; idle(9);
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      checks++; if (sw_out !== 16'h0008 || rise !== 16'h0000 || fall !== 16'h0000) begin errors++; $display("FAIL bounce_wait tick%0d: sw_out %h rise %h fall %h expected 0008 0000 0000", k, sw_out, rise, fall); end
      idle(9);
    end
    do_tick();
    checks++; if (sw_out !== 16'h0009) begin errors++; $display("FAIL bounce_accept_sw_out: got %h expected %h", sw_out, 16'h0009); end
    checks++; if (rise !== 16'h0001 || fall !== 16'h0000) begin errors++; $display("FAIL bounce_accept_pulse: rise %h fall %h expected 0001 0000", rise, fall); end
    step();
    checks++; if (rise !== 16'h0000 || changed !== 1'b0) begin errors++; $display("FAIL bounce_pulse_width: rise %h changed %b expected 0000 0", rise, changed); end
    $display("test_bounce done");
  endtask

  task automatic test_simultaneous();
    sw_in = 16'h00F0; tick = 1'b1;
    idle(8);
    checks++; if (sw_out !== 16'h00F0) begin errors++; $display("FAIL simul_setup: got %h expected %h", sw_out, 16'h00F0); end
    sw_in = 16'h0F00;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (sw_out !== 16'h00F0 || changed !== 1'b0) begin errors++; $display("FAIL simul_wait clk%0d: sw_out %h changed %b expected 00f0 0", k, sw_out, changed); end
    end
    step();
    checks++; if (sw_out !== 16'h0F00) begin errors++; $display("FAIL simul_sw_out: got %h expected %h", sw_out, 16'h0F00); end
    checks++; if (rise !== 16'h0F00) begin errors++; $display("FAIL simul_rise: got %h expected %h", rise, 16'h0F00); end
    checks++; if (fall !== 16'h00F0) begin errors++; $display("FAIL simul_fall: got %h expected %h", fall, 16'h00F0); end
    checks++; if (changed !== 1'b1) begin errors++; $display("FAIL simul_changed: got %b expected %b", changed, 1'b1); end
    step();
    checks++; if (changed !== 1'b0 || rise !== 16'h0000 || fall !== 16'h0000) begin errors++; $display("FAIL simul_pulse_width: rise %h fall %h changed %b expected 0000 0000 0", rise, fall, changed); end
    tick = 1'b0;
    $display("test_simultaneous done");
  endtask

  task automatic test_tick_gating();
    tick = 1'b0; sw_in = 16'h0F01;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++; if (sw_out !== 16'h0F00 || changed !== 1'b0) begin errors++; $display("FAIL gate_hold clk%0d: sw_out %h changed %b expected 0f00 0", i, sw_out, changed); end
    end
    for (int k = 1; k <= 3; k++) begin
      do_tick(); idle(1);
      checks++; if (sw_out !== 16'h0F00) begin errors++; $display("FAIL gate_tick%0d: got %h expected %h", k, sw_out, 16'h0F00); end
    end
    do_tick();
    checks++; if (sw_out !== 16'h0F01) begin errors++; $display("FAIL gate_accept_sw_out: got %h expected %h", sw_out, 16'h0F01); end
    checks++; if (rise !== 16'h0001 || changed !== 1'b1) begin errors++; $display("FAIL gate_accept_pulse: rise %h changed %b expected 0001 1", rise, changed); end
    $display("test_tick_gating done");
  endtask

  task automatic test_mid_reset();
    sw_in = 16'h0F21; idle(3);
    for (int k = 1; k <= 3; k++) do_tick();
    checks++; if (sw_out !== 16'h0F01) begin errors++; $display("FAIL midrst_pending: got %h expected %h", sw_out, 16'h0F01); end
    rst = 1'b1; tick = 1'b1;
    step();
    checks++; if (sw_out !== 16'h0000) begin errors++; $display("FAIL midrst_sw_out: got %h expected %h", sw_out, 16'h0000); end
    checks++; if (fall !== 16'h0000 || rise !== 16'h0000 || changed !== 1'b0) begin errors++; $display("FAIL midrst_pulses: rise %h fall %h changed %b expected 0000 0000 0", rise, fall, changed); end
    rst = 1'b0; tick = 1'b0;
    idle(2);
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      checks++; if (sw_out !== 16'h0000 || changed !== 1'b0) begin errors++; $display("FAIL midrst_wait tick%0d: sw_out %h changed %b expected 0000 0", k, sw_out, changed); end
    end
    do_tick();
    checks++; if (sw_out !== 16'h0F21) begin errors++; $display("FAIL midrst_accept_sw_out: got %h expected %h", sw_out, 16'h0F21); end
    checks++; if (rise !== 16'h0F21 || fall !== 16'h0000) begin errors++; $display("FAIL midrst_accept_pulse: rise %h fall %h expected 0f21 0000", rise, fall); end
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_tick_gating();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
